// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes, FSM states and select_z5 encodings shared by the memory-stage controller
package mem_stage_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  localparam logic [1:0] Z5_RDATA = 2'd0;
  localparam logic [1:0] Z5_ALU   = 2'd1;
  localparam logic [1:0] Z5_PC    = 2'd2;
  function automatic logic [5:0] opcode(input logic [31:0] ir);
    return ir[31:26];
  endfunction
endpackage

// File: rtl/mem_stage_ctrl_dest_decode.sv
// dest_decode: ir -> has_dest/dest register written by that instruction (ports: ir in, has_dest/dest out)
module dest_decode
  import mem_stage_pkg::*;
(
  input  logic [31:0] ir,
  output logic        has_dest,
  output logic [4:0]  dest
);
  logic [5:0] op;
  logic       unused;
  assign op       = opcode(ir);
  assign has_dest = !(op == OP_SW || op == OP_BEQ || op == OP_BNE || op == OP_J);
  assign dest     = op == OP_RTYPE ? ir[15:11] : op == OP_JAL ? 5'd31 : ir[20:16];
  assign unused   = ^{ir[25:21], ir[10:0]};
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: stage-4 decode, req/ack memory sequencing with stall/nop5 and sticky timeout (clk, reset, ir4/valid4, ir5/valid5, mem_ack in; selects, mem_req/we, stall, nop5, mem_err out)
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir4,
  input  logic        valid4,
  input  logic [31:0] ir5,
  input  logic        valid5,
  input  logic        mem_ack,
  output logic [1:0]  select_z5,
  output logic        select_writedata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        stall,
  output logic        nop5,
  output logic        mem_err
);
  logic [5:0]       op;
  logic             is_mem;
  logic             has_dest5;
  logic [4:0]       dest5;
  logic             unused;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  assign op     = opcode(ir4);
  assign is_mem = valid4 && (op == OP_LW || op == OP_SW);
  assign unused = ^{ir4[25:21], ir4[15:0]};
  dest_decode u_dest (
    .ir       (ir5),
    .has_dest (has_dest5),
    .dest     (dest5)
  );
  assign select_z5 = !valid4 ? Z5_ALU : op == OP_LW ? Z5_RDATA : op == OP_JAL ? Z5_PC : Z5_ALU;
  assign select_writedata = !(op == OP_SW && valid5 && has_dest5 && dest5 != 5'd0 && dest5 == ir4[20:16]);
  assign stall = (state == IDLE && is_mem) || state == ACCESS || state == ERR;
  assign nop5  = stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_mem) begin
          state   <= ACCESS;
          mem_req <= 1'b1;
          mem_we  <= op == OP_SW;
          cnt     <= '0;
        end
        ACCESS: if (mem_ack) begin
          state   <= DONE;
          mem_req <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= ERR;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        ERR: state <= ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: table vectors, transaction-level random model and hand sequences for mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir4, ir5;
  logic        valid4, valid5, mem_ack;
  logic [1:0]  select_z5;
  logic        select_writedata, mem_req, mem_we, stall, nop5, mem_err;
  int          checks = 0;
  int          failures = 0;
  mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .ir4              (ir4),
    .valid4           (valid4),
    .ir5              (ir5),
    .valid5           (valid5),
    .mem_ack          (mem_ack),
    .select_z5        (select_z5),
    .select_writedata (select_writedata),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .stall            (stall),
    .nop5             (nop5),
    .mem_err          (mem_err)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct {
    logic [31:0] ir4;
    logic        v4;
    logic [31:0] ir5;
    logic        v5;
    logic [1:0]  z5;
    logic        wd;
    logic        st;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [5:0] ref_dest(input logic [31:0] ir);
    case (ir[31:26])
      6'h00: return {1'b1, ir[15:11]};
      6'h03: return {1'b1, 5'd31};
      6'h2B, 6'h04, 6'h05, 6'h02: return 6'h00;
      default: return {1'b1, ir[20:16]};
    endcase
  endfunction
  function automatic logic [1:0] ref_z5(input logic [31:0] ir, input logic v);
    if (!v) return 2'd1;
    if (ir[31:26] == 6'h23) return 2'd0;
    if (ir[31:26] == 6'h03) return 2'd2;
    return 2'd1;
  endfunction
  function automatic logic ref_wd(input logic [31:0] i4, input logic [31:0] i5, input logic v5);
    logic [5:0] d;
    d = ref_dest(i5);
    return !(i4[31:26] == 6'h2B && v5 && d[5] && d[4:0] != 5'd0 && d[4:0] == i4[20:16]);
  endfunction
  function automatic logic [31:0] rnd_ir();
    logic [5:0] ops [10];
    logic [4:0] rs, rt, rd;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h03, 6'h08, 6'h04, 6'h05, 6'h02, 6'h0D, 6'h23};
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    return {ops[$urandom_range(0, 9)], rs, rt, rd, 11'($urandom)};
  endfunction
  task automatic expect_cycle(input string tag, input logic e_stall, input logic e_req,
                              input logic e_we, input logic e_err);
    @(negedge clk);
    chk({tag, ".select_z5"}, 32'(select_z5), 32'(ref_z5(ir4, valid4)));
    chk({tag, ".select_writedata"}, 32'(select_writedata), 32'(ref_wd(ir4, ir5, valid5)));
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".nop5"}, 32'(nop5), 32'(e_stall));
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
    if (e_req) chk({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(e_err));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    valid4 = 1'b0;
    valid5 = 1'b0;
    mem_ack = 1'b0;
    ir4 = '0;
    ir5 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  // a memory op acked on its n-th request cycle: 1 decode cycle, n request cycles, 1 completion cycle
  task automatic run_mem(input string tag, input int n);
    logic we;
    we = ir4[31:26] == 6'h2B;
    mem_ack = 1'($urandom);
    expect_cycle({tag, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      mem_ack = k == n;
      expect_cycle({tag, ".wait"}, 1'b1, 1'b1, we, 1'b0);
    end
    mem_ack = 1'($urandom);
    expect_cycle({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic run_alu(input string tag);
    mem_ack = 1'($urandom);
    expect_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    tbl[0]  = '{32'h00221820, 1'b1, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[1]  = '{32'h8C410004, 1'b1, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[2]  = '{32'hAC230000, 1'b1, 32'h00221820, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[3]  = '{32'hAC230000, 1'b1, 32'h00221820, 1'b0, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{32'h0C000010, 1'b1, 32'h00000000, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{32'hAC1F0000, 1'b1, 32'h0C000010, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[6]  = '{32'hAC230000, 1'b1, 32'h8C030000, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[7]  = '{32'hAC230000, 1'b1, 32'h20030005, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[8]  = '{32'hAC230000, 1'b1, 32'hAC030000, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[9]  = '{32'hAC230000, 1'b1, 32'h10030000, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[10] = '{32'hAC000000, 1'b1, 32'h00220020, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[11] = '{32'h8C430000, 1'b1, 32'h00221820, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[12] = '{32'h8C410004, 1'b0, 32'h00000000, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[13] = '{32'hAC230000, 1'b1, 32'h08030000, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[14] = '{32'hAC230000, 1'b0, 32'h00221820, 1'b1, 2'd1, 1'b0, 1'b0};
    do_reset();
    @(negedge clk);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.mem_err", 32'(mem_err), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.nop5", 32'(nop5), 32'd0);
    chk("reset.select_z5", 32'(select_z5), 32'd1);
    // decode table: each vector applied and removed between two rising edges so the FSM stays idle
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ir4 = tbl[i].ir4;
      valid4 = tbl[i].v4;
      ir5 = tbl[i].ir5;
      valid5 = tbl[i].v5;
      #1;
      chk($sformatf("tbl%0d.select_z5", i), 32'(select_z5), 32'(tbl[i].z5));
      chk($sformatf("tbl%0d.select_writedata", i), 32'(select_writedata), 32'(tbl[i].wd));
      chk($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tbl[i].st));
      valid4 = 1'b0;
    end
    @(posedge clk);
    #1;
    ir4 = 32'h00221820; valid4 = 1'b1; ir5 = '0; valid5 = 1'b0;
    run_alu("alu");
    run_alu("alu2");
    ir4 = 32'h8C410004;
    run_mem("lw3", 3);
    ir4 = 32'hAC230000; ir5 = 32'h00221820; valid5 = 1'b1;
    run_mem("sw_fwd", 1);
    ir4 = 32'h8C410004;
    run_mem("lw_edge", T);
    ir4 = 32'h8C410004;
    run_mem("lw_b2b", 2);
    ir4 = 32'h0C000010; valid5 = 1'b0;
    run_alu("jal");
    for (int i = 0; i < 150; i++) begin
      ir5 = rnd_ir();
      valid5 = $urandom_range(0, 3) != 0;
      ir4 = rnd_ir();
      valid4 = $urandom_range(0, 7) != 0;
      if (valid4 && (ir4[31:26] == 6'h23 || ir4[31:26] == 6'h2B)) run_mem("rnd_mem", $urandom_range(1, T));
      else run_alu("rnd_alu");
    end
    ir4 = 32'h8C410004; valid4 = 1'b1; ir5 = '0; valid5 = 1'b0; mem_ack = 1'b0;
    expect_cycle("to.start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < T; k++) expect_cycle("to.wait", 1'b1, 1'b1, 1'b0, 1'b0);
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) expect_cycle("to.err", 1'b1, 1'b0, 1'b0, 1'b1);
    mem_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("to.rst.stall", 32'(stall), 32'd1);
    chk("to.rst.mem_req", 32'(mem_req), 32'd0);
    chk("to.rst.mem_err", 32'(mem_err), 32'd0);
    valid4 = 1'b0;
    #1;
    chk("to.rst.idle_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    valid4 = 1'b1;
    expect_cycle("mid.start", 1'b1, 1'b0, 1'b0, 1'b0);
    expect_cycle("mid.acc1", 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    expect_cycle("mid.acc2", 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    valid4 = 1'b0;
    expect_cycle("mid.after", 1'b0, 1'b0, 1'b0, 1'b0);
    valid4 = 1'b1;
    run_mem("mid.fresh", 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
